ram_fetch_ctrl: RTL and testbench
=================================

Name: ram_fetch_ctrl

Overview:
- Sequencer that streams the frame-word RAM (36-bit words, addresses 0..LAST_ADDR, 1-cycle registered read gated by a request strobe) to the display pipeline.
- Generates the request strobe and read address, captures returned words into a 2-entry output buffer, and presents them on a valid/ready stream.
- Supports single-frame and continuous (wrap-around) scan, stop/flush, and frame-done signalling.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 36, RAM word width.
- LAST_ADDR, 3200, highest frame address; one frame = LAST_ADDR+1 words.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  begin a frame scan from address 0; sampled in IDLE only.
- i_stop  in  1  abort scan and flush; wins over i_start.
- i_continuous  in  1  1 = wrap from LAST_ADDR to 0 and keep scanning; sampled every cycle.
- o_ram_request  out  1  RAM read strobe (combinational from registered state).
- o_ram_addr  out  ADDR_W  RAM read address (registered counter).
- i_ram_data  in  DATA_W  RAM read data, valid the cycle after the edge that sampled o_ram_request.
- o_data  out  DATA_W  head word of output buffer.
- o_last  out  1  head word came from LAST_ADDR.
- o_valid  out  1  o_data/o_last valid.
- i_ready  in  1  consumer accepts; transfer = o_valid & i_ready.
- o_busy  out  1  state != IDLE.
- o_frame_done  out  1  1-cycle pulse, registered.

Behaviour:
- Reset (async assert, sync release): state IDLE, addr counter 0, in-flight flag 0, buffer empty; all outputs 0.
- FSM states:
  - IDLE: i_start & ~i_stop -> FETCH with addr=0.
  - FETCH: issue reads.
  - DRAIN: no new reads; wait for in-flight = 0 and buffer empty, then -> IDLE.
- Issue rule: o_ram_request = (state==FETCH) & (count + inflight - pop < 2), where pop = transfer this cycle and count = buffer occupancy 0..2. Each issue sets the in-flight flag with tag last=(addr==LAST_ADDR) and advances addr on the same edge.
- Address: after issuing LAST_ADDR:
  - i_continuous=1: addr -> 0, stay FETCH.
  - Else: -> DRAIN, addr holds.
  - Counter never exceeds LAST_ADDR.
- Capture: the edge after an issue, i_ram_data plus tag are written into the buffer and in-flight clears (or stays set if a new issue happens on the same edge).
- Buffer: 2-entry FIFO, head on o_data/o_last. Simultaneous push and pop allowed at any occupancy. Overflow is impossible by the issue rule; an assertion in the bench checks it.
- Latency: i_start sampled at edge E0 -> o_ram_request high in cycle after E0 -> RAM samples at E1 -> captured at E2 -> o_valid high after E2. With i_ready held at 1, throughput is 1 word/cycle.
- Backpressure: o_data/o_last stay stable while o_valid & ~i_ready. No word is lost or duplicated.
- o_frame_done: pulses the cycle after a transfer with o_last=1, in both single-frame and continuous mode.
- i_stop (any state): on that edge, buffer is emptied, in-flight result is discarded, addr -> 0, state -> IDLE. o_valid=0 and o_ram_request=0 from the next cycle. No frame_done is generated.
- i_start while busy: ignored.
- i_continuous deasserted mid-frame: the current frame completes, then DRAIN.
- Async reset mid-scan: immediate return to reset values. A RAM word still arriving is ignored.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs -> all outputs 0. Release, no start -> outputs stay 0, o_busy=0.
- Single frame, RAM word n = n, i_ready=1: start at E0 -> o_valid first high after E2 with o_data=0. Data increments by 1 every cycle through 3200 with o_last=1 on 3200. o_frame_done pulses once, o_busy=0 two cycles later, exactly 3201 transfers.
- Backpressure: i_ready=0 for 10 cycles at word 5 -> at most 2 buffered, o_ram_request=0 after buffer full, o_data held at 5. Resume -> 5,6,7,... with no gaps or duplicates. Random i_ready over a full frame -> in-order 0..3200.
- Continuous: i_continuous=1, i_ready=1 -> sequence ...,3199,3200,0,1,... with o_frame_done after each 3200 transfer. Drop i_continuous mid-frame -> ends after 3200, returns to IDLE.
- Stop: i_stop at word 100 while buffer full and read in flight -> next cycle o_valid=0, o_busy=0, no frame_done. New i_start -> first word 0.
- Corner cases: i_start and i_stop in the same cycle -> remains IDLE. i_start during FETCH -> no effect. Async reset pulse at word 2000 -> outputs 0 immediately. Restart -> clean frame from 0.

Source files
------------

// File: rtl/ram_fetch_ctrl_if.sv
// Bundle that connects the fetch sequencer to the frame-word RAM read port
// and to the downstream valid/ready word stream.
interface ram_fetch_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 36
);
    logic              o_ram_request;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] i_ram_data;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic              o_valid;
    logic              i_ready;

    modport master (
        output o_ram_request,
        output o_ram_addr,
        input  i_ram_data,
        output o_data,
        output o_last,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_ram_request,
        input  o_ram_addr,
        output i_ram_data,
        input  o_data,
        input  o_last,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/ram_fetch_ctrl.sv
// Streams frame words 0..LAST_ADDR out of a registered-read RAM into a
// 2-entry output buffer, with single-frame or wrap-around scanning.
module ram_fetch_ctrl #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 36,
    parameter int LAST_ADDR = 3200
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_continuous,
    output logic             o_busy,
    output logic             o_frame_done,
    ram_fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              inflight_reg, inflight_next;
    logic              inflight_last_reg, inflight_last_next;
    logic              frame_done_reg;

    logic       wr_ptr_reg, rd_ptr_reg;
    logic [1:0] count_reg;

    logic       head_last;
    logic       valid;
    logic       pop;
    logic       push_en;
    logic       issue;
    logic       at_last;
    logic [2:0] pending;

    // Words owed to the buffer after this edge: held + in flight - leaving.
    assign valid   = (count_reg != 2'd0);
    assign pop     = valid & bus.i_ready;
    assign push_en = inflight_reg & ~i_stop;
    assign pending = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign issue   = (state_reg == ST_FETCH) && (pending < 3'd2);
    assign at_last = (addr_reg == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg         <= ST_IDLE;
            addr_reg          <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            addr_reg          <= addr_next;
            inflight_reg      <= inflight_next;
            inflight_last_reg <= inflight_last_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        addr_next          = addr_reg;
        inflight_next      = issue;
        inflight_last_next = issue ? at_last : inflight_last_reg;

        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = ST_FETCH;
                    addr_next  = '0;
                end
            end
            ST_FETCH: begin
                if (issue) begin
                    if (at_last) begin
                        if (i_continuous) begin
                            addr_next = '0;
                        end else begin
                            state_next = ST_DRAIN;
                        end
                    end else begin
                        addr_next = addr_reg + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_reg && (count_reg == 2'd0)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Stop overrides everything, including a start in the same cycle.
        if (i_stop) begin
            state_next    = ST_IDLE;
            addr_next     = '0;
            inflight_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (i_stop) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg ^ push_en;
            rd_ptr_reg <= rd_ptr_reg ^ pop;
            count_reg  <= count_reg + {1'b0, push_en} - {1'b0, pop};
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            localparam logic SLOT = 1'(gi);
            logic [DATA_W-1:0] data_reg;
            logic              last_reg;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    data_reg <= '0;
                    last_reg <= 1'b0;
                end else if (push_en && (wr_ptr_reg == SLOT)) begin
                    data_reg <= bus.i_ram_data;
                    last_reg <= inflight_last_reg;
                end
            end
        end
    endgenerate

    assign head_last = rd_ptr_reg ? g_slot[1].last_reg : g_slot[0].last_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= pop & head_last & ~i_stop;
        end
    end

    assign bus.o_ram_request = issue;
    assign bus.o_ram_addr    = addr_reg;
    assign bus.o_data        = rd_ptr_reg ? g_slot[1].data_reg : g_slot[0].data_reg;
    assign bus.o_last        = head_last;
    assign bus.o_valid       = valid;
    assign o_busy            = (state_reg != ST_IDLE);
    assign o_frame_done      = frame_done_reg;

endmodule

// File: tb/tb_ram_fetch_ctrl.sv
// Randomised bench for ram_fetch_ctrl: a RAM model feeds the DUT, expected
// words are queued per frame and a negedge monitor checks every transfer.
module tb_ram_fetch_ctrl;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 36;
    localparam int LAST_ADDR = 3200;
    localparam int FRAME     = LAST_ADDR + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stop  = 1'b0;
    logic cont  = 1'b0;
    logic busy;
    logic frame_done;

    ram_fetch_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_fetch_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LAST_ADDR(LAST_ADDR)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_stop      (stop),
        .i_continuous(cont),
        .o_busy      (busy),
        .o_frame_done(frame_done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [FRAME];
    exp_t exp_q [$];
    exp_t mon_e;

    int   errors   = 0;
    int   checks   = 0;
    int   xfer_cnt = 0;
    int   fd_count = 0;
    logic fd_expect = 1'b0;
    int   issued   = 0;
    int   retired  = 0;

    // RAM: registered read, only when strobed; noise while in reset.
    always @(posedge clk) begin
        if (!rst_n)
            bus.i_ram_data <= DATA_W'({$urandom(), $urandom()});
        else if (bus.o_ram_request)
            bus.i_ram_data <= mem[bus.o_ram_addr];
    end

    // Reads issued but not yet consumed can never exceed the buffer depth.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || stop) begin
            issued  <= 0;
            retired <= 0;
        end else begin
            if (bus.o_ram_request) issued <= issued + 1;
            if (bus.o_valid && bus.i_ready) retired <= retired + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            fd_expect = 1'b0;
        end else begin
            chk("frame_done", 64'(frame_done), 64'(fd_expect));
            checks++;
            if (issued - retired > 2) begin
                errors++;
                $display("FAIL overflow: outstanding %0d expected <= 2", issued - retired);
            end
            fd_expect = 1'b0;
            if (bus.o_valid && bus.i_ready && !stop) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", bus.o_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("data", 64'(bus.o_data), 64'(mon_e.data));
                    chk("last", 64'(bus.o_last), 64'(mon_e.last));
                    fd_expect = mon_e.last;
                end
                xfer_cnt++;
            end
            if (frame_done) fd_count++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        exp_t e;
        for (int a = 0; a < FRAME; a++) begin
            e.data = mem[a];
            e.last = (a == LAST_ADDR);
            exp_q.push_back(e);
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < FRAME; a++) mem[a] = DATA_W'({$urandom(), $urandom()});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_xfers(input int target, input int budget, input string name);
        int n = 0;
        while (xfer_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(xfer_cnt >= target), 64'd1);
    endtask

    task automatic wait_fd(input int target, input int budget, input bit rand_ready, input string name);
        int n = 0;
        while (fd_count < target && n < budget) begin
            tick();
            if (rand_ready) bus.i_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        bus.i_ready = 1'b1;
        chk(name, 64'(fd_count), 64'(target));
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
        chk({tag, "_data"}, 64'(bus.o_data), 64'd0);
        chk({tag, "_last"}, 64'(bus.o_last), 64'd0);
        chk({tag, "_req"}, 64'(bus.o_ram_request), 64'd0);
        chk({tag, "_addr"}, 64'(bus.o_ram_addr), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_fdone"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        int base;
        int fd0;
        int cnt;

        bus.i_ready = 1'b0;
        for (int a = 0; a < FRAME; a++) mem[a] = DATA_W'(a);

        // Reset held with random inputs, then released with nothing started.
        for (int i = 0; i < 6; i++) begin
            tick();
            start = 1'($urandom()); stop = 1'($urandom());
            cont  = 1'($urandom()); bus.i_ready = 1'($urandom());
            #2;
            chk_all_zero("reset");
        end
        start = 1'b0; stop = 1'b0; cont = 1'b0; bus.i_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all_zero("post_reset");
        end
        $display("step reset: checks=%0d errors=%0d", checks, errors);

        // Single frame, word n = n, consumer always ready.
        push_frame();
        base = xfer_cnt;
        fd0  = fd_count;
        pulse_start();
        chk("lat_e0_busy", 64'(busy), 64'd1);
        chk("lat_e0_req", 64'(bus.o_ram_request), 64'd1);
        chk("lat_e0_valid", 64'(bus.o_valid), 64'd0);
        tick();
        chk("lat_e1_valid", 64'(bus.o_valid), 64'd0);
        tick();
        chk("lat_e2_valid", 64'(bus.o_valid), 64'd1);
        chk("lat_e2_data", 64'(bus.o_data), 64'd0);
        cnt = 0;
        while (fd_count == fd0 && cnt < FRAME + 50) begin
            tick();
            cnt++;
        end
        chk("throughput_cycles", 64'(cnt), 64'(FRAME + 1));
        chk("single_busy_off", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("single_fd_once", 64'(fd_count - fd0), 64'd1);
        chk("single_xfers", 64'(xfer_cnt - base), 64'(FRAME));
        chk("single_queue", 64'(exp_q.size()), 64'd0);
        $display("step single_frame: checks=%0d errors=%0d", checks, errors);

        // Backpressure at word 5, then random ready for the rest of the frame.
        fill_random();
        push_frame();
        base = xfer_cnt;
        fd0  = fd_count;
        pulse_start();
        wait_xfers(base + 5, 50, "bp_reach_5");
        bus.i_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("bp_valid", 64'(bus.o_valid), 64'd1);
            chk("bp_data", 64'(bus.o_data), 64'(mem[5]));
            if (i >= 1) chk("bp_req", 64'(bus.o_ram_request), 64'd0);
            tick();
        end
        wait_fd(fd0 + 1, 6 * FRAME, 1'b1, "bp_frame_done");
        wait_idle(20, "bp_idle");
        chk("bp_xfers", 64'(xfer_cnt - base), 64'(FRAME));
        chk("bp_queue", 64'(exp_q.size()), 64'd0);
        $display("step backpressure: checks=%0d errors=%0d", checks, errors);

        // Continuous scan over three frames; start while busy must be ignored.
        fill_random();
        push_frame(); push_frame(); push_frame();
        base = xfer_cnt;
        fd0  = fd_count;
        cont = 1'b1;
        pulse_start();
        wait_xfers(base + FRAME + 500, 2 * FRAME, "cont_mid");
        pulse_start();
        wait_xfers(base + 2 * FRAME + 1000, 2 * FRAME, "cont_third");
        cont = 1'b0;
        wait_fd(fd0 + 3, 2 * FRAME, 1'b0, "cont_frame_done");
        wait_idle(20, "cont_idle");
        chk("cont_xfers", 64'(xfer_cnt - base), 64'(3 * FRAME));
        chk("cont_queue", 64'(exp_q.size()), 64'd0);
        $display("step continuous: checks=%0d errors=%0d", checks, errors);

        // Stop at word 100 with a word buffered and a read in flight.
        push_frame();
        base = xfer_cnt;
        fd0  = fd_count;
        pulse_start();
        wait_xfers(base + 100, 200, "stop_reach_100");
        bus.i_ready = 1'b0;
        stop = 1'b1;
        exp_q.delete();
        tick();
        stop = 1'b0;
        chk("stop_valid", 64'(bus.o_valid), 64'd0);
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_req", 64'(bus.o_ram_request), 64'd0);
        bus.i_ready = 1'b1;
        repeat (5) tick();
        chk("stop_no_fd", 64'(fd_count), 64'(fd0));
        push_frame();
        pulse_start();
        wait_fd(fd0 + 1, FRAME + 50, 1'b0, "stop_restart_fd");
        wait_idle(20, "stop_restart_idle");
        chk("stop_restart_queue", 64'(exp_q.size()), 64'd0);
        $display("step stop: checks=%0d errors=%0d", checks, errors);

        // Start and stop together in idle.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("ss_busy", 64'(busy), 64'd0);
        chk("ss_req", 64'(bus.o_ram_request), 64'd0);
        tick();
        chk("ss_busy2", 64'(busy), 64'd0);
        chk("ss_valid", 64'(bus.o_valid), 64'd0);
        $display("step start_stop: checks=%0d errors=%0d", checks, errors);

        // Async reset pulse mid-scan, then a clean restart.
        fill_random();
        push_frame();
        base = xfer_cnt;
        fd0  = fd_count;
        pulse_start();
        wait_xfers(base + 2000, 2100, "rst_reach_2000");
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        push_frame();
        base = xfer_cnt;
        pulse_start();
        wait_fd(fd0 + 1, FRAME + 50, 1'b0, "rst_restart_fd");
        wait_idle(20, "rst_restart_idle");
        chk("rst_restart_xfers", 64'(xfer_cnt - base), 64'(FRAME));
        chk("rst_restart_queue", 64'(exp_q.size()), 64'd0);
        $display("step async_reset: checks=%0d errors=%0d", checks, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
